// File: rtl/rf_wb_arbiter_if.sv
// Bundle of the register-file write-port arbiter signals: pipeline WB request,
// M-unit result handshake, register-file write port and hazard/stall feedback.
interface rf_wb_arbiter_if #(
  parameter int DEPTH = 2
);
  logic                     p_we;
  logic [4:0]               p_waddr;
  logic [31:0]              p_wd;
  logic                     m_valid;
  logic                     m_ready;
  logic [4:0]               m_waddr;
  logic [31:0]              m_wd;
  logic                     rf_we;
  logic [4:0]               rf_waddr;
  logic [31:0]              rf_wd;
  logic                     stall_req;
  logic [31:0]              pend_mask;
  logic [$clog2(DEPTH):0]   fifo_cnt;

  modport master (
    output p_we, p_waddr, p_wd, m_valid, m_waddr, m_wd,
    input  m_ready, rf_we, rf_waddr, rf_wd, stall_req, pend_mask, fifo_cnt
  );

  modport slave (
    input  p_we, p_waddr, p_wd, m_valid, m_waddr, m_wd,
    output m_ready, rf_we, rf_waddr, rf_wd, stall_req, pend_mask, fifo_cnt
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between pipeline WB (fixed priority) and a
// small FIFO of M-unit results. Define RF_ARB_BYPASS_EN for same-cycle M bypass.
module rf_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  rf_wb_arbiter_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT) + 1;

  localparam logic [CW-1:0] C_FULL        = CW'(DEPTH);
  localparam logic [CW-1:0] C_LAST_POP    = CW'(DEPTH - 1);
  localparam logic [SW-1:0] C_STARVE_LAST = SW'(STARVE_LIMIT - 1);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  logic [4:0]    r_addr_mem [DEPTH];
  logic [31:0]   r_data_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_pend;
  logic [0:0]    r_state;
  logic [SW-1:0] r_starve;
  logic [CW-1:0] r_stall_pops;

  logic          w_fifo_ne;
  logic          w_full;
  logic          w_p_req;
  logic          w_m_req;
  logic          w_g_pipe;
  logic          w_g_fifo;
  logic          w_g_byp;
  logic          w_push;
  logic          w_pop;
  logic [4:0]    w_head_addr;
  logic [31:0]   w_head_data;
  logic          w_rf_we;
  logic [4:0]    w_rf_waddr;
  logic [31:0]   w_rf_wd;
  logic [31:0]   w_push_bit;
  logic [31:0]   w_pop_bit;

  assign w_head_addr = r_addr_mem[r_rd_ptr];
  assign w_head_data = r_data_mem[r_rd_ptr];

  // Grant decision: pipeline first, then FIFO head (or direct M bypass when enabled).
  always_comb begin
    w_fifo_ne = (r_cnt != CW'(0));
    w_full    = (r_cnt == C_FULL);
    w_p_req   = (r_state == ST_RUN) && bus.p_we && (bus.p_waddr != 5'd0);
    w_m_req   = bus.m_valid && (bus.m_waddr != 5'd0);
    w_g_pipe  = w_p_req;
    w_g_fifo  = !w_p_req && w_fifo_ne;
`ifdef RF_ARB_BYPASS_EN
    w_g_byp   = !w_p_req && !w_fifo_ne && w_m_req;
`else
    w_g_byp   = 1'b0;
`endif
    w_push    = w_m_req && !w_full && !w_g_byp;
    w_pop     = w_g_fifo;
  end

  // Register-file write-port mux; idle cycles drive zero address and data.
  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_waddr = 5'd0;
    w_rf_wd    = 32'd0;
    if (w_g_pipe) begin
      w_rf_we    = 1'b1;
      w_rf_waddr = bus.p_waddr;
      w_rf_wd    = bus.p_wd;
    end else if (w_g_fifo) begin
      w_rf_we    = 1'b1;
      w_rf_waddr = w_head_addr;
      w_rf_wd    = w_head_data;
    end else if (w_g_byp) begin
      w_rf_we    = 1'b1;
      w_rf_waddr = bus.m_waddr;
      w_rf_wd    = bus.m_wd;
    end else begin
      w_rf_we    = 1'b0;
      w_rf_waddr = 5'd0;
      w_rf_wd    = 32'd0;
    end
  end

  // One-hot set/clear vectors for the pending-destination mask.
  always_comb begin
    w_push_bit = 32'd0;
    w_pop_bit  = 32'd0;
    if (w_push) begin
      w_push_bit = 32'd1 << bus.m_waddr;
    end else begin
      w_push_bit = 32'd0;
    end
    if (w_pop) begin
      w_pop_bit = 32'd1 << w_head_addr;
    end else begin
      w_pop_bit = 32'd0;
    end
  end

  // M-result FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_cnt    <= CW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        r_addr_mem[i] <= 5'd0;
        r_data_mem[i] <= 32'd0;
      end
    end else begin
      if (w_push) begin
        r_addr_mem[r_wr_ptr] <= bus.m_waddr;
        r_data_mem[r_wr_ptr] <= bus.m_wd;
        r_wr_ptr             <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Pending mask: a push to the same index outranks a pop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 32'd0;
    end else begin
      r_pend <= (r_pend & ~w_pop_bit) | w_push_bit;
    end
  end

  // Starvation guard: freeze WB after STARVE_LIMIT denied cycles, drain up to DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_starve     <= SW'(0);
      r_stall_pops <= CW'(0);
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_fifo_ne && w_g_pipe) begin
            if (r_starve == C_STARVE_LAST) begin
              r_state      <= ST_STALL;
              r_starve     <= SW'(0);
              r_stall_pops <= CW'(0);
            end else begin
              r_starve <= r_starve + SW'(1);
            end
          end else begin
            r_starve <= SW'(0);
          end
        end
        ST_STALL: begin
          if (!w_fifo_ne) begin
            r_state <= ST_RUN;
          end else if (w_pop) begin
            if (((r_cnt == CW'(1)) && !w_push) || (r_stall_pops == C_LAST_POP)) begin
              r_state <= ST_RUN;
            end
            r_stall_pops <= r_stall_pops + CW'(1);
          end
        end
        default: begin
          r_state      <= ST_RUN;
          r_starve     <= SW'(0);
          r_stall_pops <= CW'(0);
        end
      endcase
    end
  end

  assign bus.m_ready   = !w_full;
  assign bus.rf_we     = w_rf_we;
  assign bus.rf_waddr  = w_rf_waddr;
  assign bus.rf_wd     = w_rf_wd;
  assign bus.stall_req = (r_state == ST_STALL);
  assign bus.pend_mask = r_pend;
  assign bus.fifo_cnt  = r_cnt;

endmodule
